// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single-port synchronous memory.
// Serialises req/ack transactions from port 0 (CPU) and port 1; all outputs are registered.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 16,
  parameter int unsigned DW      = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          p0_req,
  input  logic          p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_ack,
  output logic          p0_gnt,
  input  logic          p1_req,
  input  logic          p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_ack,
  output logic          p1_gnt,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e        r_state, w_state_d;
  logic          r_last, w_last_d;
  logic [2:0]    r_cnt, w_cnt_d;
  logic [AW-1:0] r_mem_addr, w_mem_addr_d;
  logic [DW-1:0] r_mem_wdata, w_mem_wdata_d;
  logic          r_mem_we, w_mem_we_d;
  logic [DW-1:0] r_p0_rdata, w_p0_rdata_d;
  logic [DW-1:0] r_p1_rdata, w_p1_rdata_d;
  logic          r_p0_ack, w_p0_ack_d;
  logic          r_p1_ack, w_p1_ack_d;
  logic          r_p0_gnt, w_p0_gnt_d;
  logic          r_p1_gnt, w_p1_gnt_d;
  logic          r_busy, w_busy_d;
  logic          w_win;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_last      <= 1'b1;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_p0_gnt    <= 1'b0;
      r_p1_gnt    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_last      <= w_last_d;
      r_cnt       <= w_cnt_d;
      r_mem_addr  <= w_mem_addr_d;
      r_mem_wdata <= w_mem_wdata_d;
      r_mem_we    <= w_mem_we_d;
      r_p0_rdata  <= w_p0_rdata_d;
      r_p1_rdata  <= w_p1_rdata_d;
      r_p0_ack    <= w_p0_ack_d;
      r_p1_ack    <= w_p1_ack_d;
      r_p0_gnt    <= w_p0_gnt_d;
      r_p1_gnt    <= w_p1_gnt_d;
      r_busy      <= w_busy_d;
    end
  end

  always_comb begin
    w_state_d     = r_state;
    w_last_d      = r_last;
    w_cnt_d       = r_cnt;
    w_mem_addr_d  = r_mem_addr;
    w_mem_wdata_d = r_mem_wdata;
    w_mem_we_d    = 1'b0;
    w_p0_rdata_d  = r_p0_rdata;
    w_p1_rdata_d  = r_p1_rdata;
    w_p0_ack_d    = 1'b0;
    w_p1_ack_d    = 1'b0;
    w_p0_gnt_d    = r_p0_gnt;
    w_p1_gnt_d    = r_p1_gnt;
    // 1 selects port 1; on contention the port that did not win last time goes first
    w_win         = (p0_req && p1_req) ? ~r_last : p1_req;

    unique case (r_state)
      StIdle: begin
        if (p0_req || p1_req) begin
          w_state_d     = StAccess;
          w_last_d      = w_win;
          w_p0_gnt_d    = ~w_win;
          w_p1_gnt_d    = w_win;
          w_mem_addr_d  = w_win ? p1_addr : p0_addr;
          w_mem_wdata_d = w_win ? p1_wdata : p0_wdata;
          w_mem_we_d    = w_win ? p1_we : p0_we;
        end
      end
      StAccess: begin
        w_state_d = StWait;
        w_cnt_d   = 3'(MEM_LAT - 1);
      end
      StWait: begin
        if (r_cnt == 3'd0) begin
          w_state_d = StResp;
          if (r_p1_gnt) begin
            w_p1_rdata_d = mem_rdata;
            w_p1_ack_d   = 1'b1;
          end else begin
            w_p0_rdata_d = mem_rdata;
            w_p0_ack_d   = 1'b1;
          end
        end else begin
          w_cnt_d = r_cnt - 3'd1;
        end
      end
      StResp: begin
        w_state_d  = StIdle;
        w_p0_gnt_d = 1'b0;
        w_p1_gnt_d = 1'b0;
      end
      default: w_state_d = StIdle;
    endcase

    w_busy_d = (w_state_d != StIdle);
  end

  assign p0_rdata  = r_p0_rdata;
  assign p1_rdata  = r_p1_rdata;
  assign p0_ack    = r_p0_ack;
  assign p1_ack    = r_p1_ack;
  assign p0_gnt    = r_p0_gnt;
  assign p1_gnt    = r_p1_gnt;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we    = r_mem_we;
  assign busy      = r_busy;

endmodule
